pearson_hash: RTL and testbench
===============================

PEARSON_HASH -- requirements
Module: pearson_hash

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  key offered this cycle.
REQ-005 in_ready  output  1  block idle and able to accept a key.
REQ-006 key  input  40  5-byte key; key[39:32] is the first byte hashed, key[7:0] the last.
REQ-007 out_valid  output  1  one-cycle pulse marking a new hash.
REQ-008 hash  output  8  Pearson hash of the last accepted key.
REQ-009 key_out  output  40  key that produced the current hash; present only with PEARSON_KEY_ECHO_EN.

Function
REQ-010 Permutation table SHALL be T[x] = (((x XOR 8'hA5) * 29) + 101) mod 256 for x in 0..255, as a 256-entry ROM or equivalent logic.
REQ-011 Hash SHALL be h=0, then for bytes B4..B0 (B4=key[39:32]): h = T[h XOR Bi]; the result is the final h.
REQ-012 States SHALL be IDLE and RUN, with a 3-bit byte index (4 down to 0).
REQ-013 in_ready SHALL be 1 exactly when state is IDLE.
REQ-014 Key SHALL be accepted at a rising edge with in_valid=1 and in_ready=1; the edge registers the key, clears h, sets index=4 and enters RUN.
REQ-015 In RUN, each edge SHALL process one byte (h = T[h XOR B[index]]) and decrement the index.
REQ-016 The edge processing index 0 SHALL load hash, set out_valid=1 for one cycle and return to IDLE.
REQ-017 Latency SHALL be 5 edges from the accept edge to out_valid; a new key may be accepted in the out_valid cycle, giving a maximum throughput of one key per 6 cycles.
REQ-018 in_valid while busy SHALL be ignored; the key is sampled only at the accept edge, so later key changes do not affect the result.
REQ-019 hash SHALL hold its value until the next completion.
REQ-020 out_valid SHALL never assert without a prior accept.

Reset
REQ-021 rst_n=0 SHALL, asynchronously, set state=IDLE, hash=0, out_valid=0, internal h=0, index=0 and key_out=0.
REQ-022 Reset during RUN SHALL abort the operation with no out_valid.
REQ-023 After reset deassertion, in_ready SHALL be 1 and the first accept SHALL behave as in REQ-014.

Configuration
REQ-024 Macro PEARSON_KEY_ECHO_EN: when defined, key_out SHALL exist, load the accepted key on the completion edge (REQ-016) and hold with hash.
REQ-025 Without PEARSON_KEY_ECHO_EN, the key_out port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Reset mid-RUN (2 edges after accept) -> out_valid never pulses; hash=0 and in_ready=1 after reset.
REQ-027 Accept key=40'h0 -> after 5 edges out_valid pulses once and hash=142 (0x8E).
REQ-028 Accept key=40'h61_0000_0000 -> hash=57 (0x39).
REQ-029 Accept key=40'h68_656C_6C6F ("hello") -> hash=138 (0x8A); with the macro defined, key_out=40'h68656C6C6F.
REQ-030 Back-to-back accept of "hello" then 40'h0 in the out_valid cycle -> two pulses 6 cycles apart, hash 138 then 142; in_valid pulses during RUN are ignored.
REQ-031 Change key during RUN -> result still equals the hash of the key accepted at the accept edge.

Source files
------------

// File: rtl/pearson_hash.sv
// Sequential 8-bit Pearson hash of a 5-byte key, one byte per clock.
// Optional macro PEARSON_KEY_ECHO_EN adds key_out, the key that produced the current hash.
module pearson_hash (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] key,
    output logic        out_valid,
    output logic [7:0]  hash
`ifdef PEARSON_KEY_ECHO_EN
    ,
    output logic [39:0] key_out
`endif
);

    localparam int unsigned KEY_W  = 40;
    localparam int unsigned HASH_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [HASH_W-1:0]   h, h_n;
    logic [KEY_W-1:0]    key_reg, key_reg_n;
    logic [HASH_W-1:0]   hash_n;
    logic                out_valid_n;
    logic                ready_n;
    logic [HASH_W-1:0]   cur_byte;
    logic [HASH_W-1:0]   step;
`ifdef PEARSON_KEY_ECHO_EN
    logic [KEY_W-1:0]    key_out_n;
`endif

    // Permutation: T[x] = ((x ^ A5) * 29 + 101) mod 256; 8-bit arithmetic wraps naturally.
    function automatic logic [HASH_W-1:0] perm(input logic [HASH_W-1:0] x);
        logic [HASH_W-1:0] t;
        t = x ^ 8'hA5;
        return t * 8'd29 + 8'd101;
    endfunction

    // Byte idx of the registered key; idx 4 is the most significant byte.
    assign cur_byte = HASH_W'(key_reg >> {idx, 3'b000});
    assign step     = perm(h ^ cur_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            h         <= '0;
            key_reg   <= '0;
            hash      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef PEARSON_KEY_ECHO_EN
            key_out   <= '0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            h         <= h_n;
            key_reg   <= key_reg_n;
            hash      <= hash_n;
            out_valid <= out_valid_n;
            in_ready  <= ready_n;
`ifdef PEARSON_KEY_ECHO_EN
            key_out   <= key_out_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        h_n         = h;
        key_reg_n   = key_reg;
        hash_n      = hash;
        out_valid_n = 1'b0;
`ifdef PEARSON_KEY_ECHO_EN
        key_out_n   = key_out;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    key_reg_n = key;
                    h_n       = '0;
                    idx_n     = IDX_W'(4);
                    state_n   = RUN;
                end
            end
            RUN: begin
                h_n = step;
                if (idx == '0) begin
                    hash_n      = step;
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
`ifdef PEARSON_KEY_ECHO_EN
                    key_out_n   = key_reg;
`endif
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // in_ready is a registered copy of (state == IDLE).
        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_pearson_hash.sv
// Directed self-checking bench for pearson_hash using hand-computed hashes.
module tb_pearson_hash;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] key;
    logic        out_valid;
    logic [7:0]  hash;
`ifdef PEARSON_KEY_ECHO_EN
    logic [39:0] key_out;
`endif

    int checks;
    int errors;

    pearson_hash dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .out_valid (out_valid),
        .hash      (hash)
`ifdef PEARSON_KEY_ECHO_EN
        ,
        .key_out   (key_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept k, check the 5-edge latency, the single pulse, the hash and that it holds.
    task automatic run_key(input logic [39:0] k, input logic [7:0] exp, input string tag);
        key      = k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy_ready"}, 40'(in_ready), 40'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("%s_early_valid_%0d", tag, i), 40'(out_valid), 40'd0);
        end
        tick();
        chk({tag, "_valid"}, 40'(out_valid), 40'd1);
        chk({tag, "_hash"}, 40'(hash), 40'(exp));
        chk({tag, "_ready_done"}, 40'(in_ready), 40'd1);
`ifdef PEARSON_KEY_ECHO_EN
        chk({tag, "_key_out"}, key_out, k);
`endif
        tick();
        chk({tag, "_pulse_end"}, 40'(out_valid), 40'd0);
        chk({tag, "_hash_hold"}, 40'(hash), 40'(exp));
    endtask

    initial begin
        int pulses;
        int gap;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        key      = '0;

        tick();
        tick();
        chk("rst_ready", 40'(in_ready), 40'd1);
        chk("rst_valid", 40'(out_valid), 40'd0);
        chk("rst_hash", 40'(hash), 40'd0);
`ifdef PEARSON_KEY_ECHO_EN
        chk("rst_key_out", key_out, 40'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 40'(in_ready), 40'd1);

        run_key(40'h00_0000_0000, 8'h8E, "zero");
        run_key(40'h61_0000_0000, 8'h39, "a");
        run_key(40'h68_656C_6C6F, 8'h8A, "hello");

        // Back-to-back: busy-time in_valid pulses ignored, second key accepted in the pulse cycle.
        key      = 40'h68_656C_6C6F;
        in_valid = 1'b1;
        tick();
        for (int i = 1; i < 5; i++) begin
            in_valid = i[0];
            key      = 40'hFF_FFFF_FFFF;
            tick();
            chk($sformatf("b2b_first_early_%0d", i), 40'(out_valid), 40'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_first_valid", 40'(out_valid), 40'd1);
        chk("b2b_first_hash", 40'(hash), 40'h8A);
        key      = 40'h0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("b2b_accept_busy", 40'(in_ready), 40'd0);
        gap = 1;
        while (out_valid !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        chk("b2b_gap", 40'(gap), 40'd6);
        chk("b2b_second_hash", 40'(hash), 40'h8E);
        tick();

        // Key change after accept must not affect the result.
        key      = 40'h0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        key      = 40'h68_656C_6C6F;
        for (int i = 1; i < 5; i++) tick();
        tick();
        chk("keychg_valid", 40'(out_valid), 40'd1);
        chk("keychg_hash", 40'(hash), 40'h8E);
        tick();

        // Reset two edges after accept aborts the operation.
        key      = 40'h61_0000_0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 40'(in_ready), 40'd1);
        chk("abort_hash", 40'(hash), 40'd0);
        chk("abort_valid", 40'(out_valid), 40'd0);
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        chk("abort_no_pulse", 40'(pulses), 40'd0);
        chk("abort_ready_after", 40'(in_ready), 40'd1);
        chk("abort_hash_after", 40'(hash), 40'd0);

        run_key(40'h61_0000_0000, 8'h39, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
